// File: rtl/io_mem_target.sv
// io_mem_target -- responder end of the req/ack/rw/adr/dtw/dtr memory bus.
// Services one word transaction at a time from internal RAM. Each transaction
// gets WAIT wait states, then a single-cycle ack. Addresses outside the
// window raise err together with ack.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   req   in   transaction request
//   rw    in   1 = read, 0 = write
//   adr   in   byte address (adr[0] ignored)
//   dtw   in   write data
//   dtr   out  registered read data (all-ones on out-of-window read)
//   ack   out  one-cycle completion strobe
//   err   out  out-of-window flag, valid with ack, held until next response
//   busy  out  high whenever the FSM is not idle
module io_mem_target #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE = 20'h00000,
  parameter int unsigned WAIT       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] dtw,
  output logic [DATA_W-1:0] dtr,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

  localparam logic [ADDR_W-1:0] BASE_V = BASE;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic latch, enter_resp;

  // Latched transaction, word-addressed (byte lane bit dropped).
  logic              l_rw;
  logic [ADDR_W-2:0] l_wa;
  logic [DATA_W-1:0] l_dtw;

  logic              op_rw;
  logic [ADDR_W-2:0] op_wa;
  logic [DATA_W-1:0] op_dtw;
  logic              in_win;
  logic [DEPTH_LOG2-1:0] idx;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  logic unused_adr0;
  assign unused_adr0 = adr[0];

  // With WAIT=0 the response happens on the same edge that samples req, so
  // the live inputs are used while in IDLE and the latched copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      op_rw  = rw;
      op_wa  = adr[ADDR_W-1:1];
      op_dtw = dtw;
    end else begin
      op_rw  = l_rw;
      op_wa  = l_wa;
      op_dtw = l_dtw;
    end
  end

  assign in_win = (op_wa[ADDR_W-2:DEPTH_LOG2] == BASE_V[ADDR_W-1:DEPTH_LOG2+1]);
  assign idx    = op_wa[DEPTH_LOG2-1:0];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch      = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (WAIT > 0) begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(WAIT);
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      l_rw  <= 1'b0;
      l_wa  <= '0;
      l_dtw <= '0;
      dtr   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        l_rw  <= rw;
        l_wa  <= adr[ADDR_W-1:1];
        l_dtw <= dtw;
      end
      if (enter_resp) begin
        if (in_win) begin
          err <= 1'b0;
          if (op_rw) dtr <= mem[idx];
        end else begin
          err <= 1'b1;
          if (op_rw) dtr <= '1;
        end
      end
    end
  end

  // RAM is never cleared; reset forces IDLE so an abandoned write cannot land.
  always_ff @(posedge clk) begin
    if (enter_resp && in_win && !op_rw) mem[idx] <= op_dtw;
  end

  assign ack  = (state == RESP);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_io_mem_target.sv
module tb_io_mem_target;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        rw  = 1'b0;
  logic [19:0] adr = '0;
  logic [15:0] dtw = '0;
  logic [15:0] dtr;
  logic        ack, err, busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  io_mem_target #(
    .ADDR_W(20), .DATA_W(16), .DEPTH_LOG2(10), .BASE(20'h00000), .WAIT(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .adr(adr), .dtw(dtw),
    .dtr(dtr), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: req presented for one edge (t0), then inputs scrambled
  // to show they are ignored. acks/busys bit k = value sampled after t0+k.
  task automatic txn(input string tag, input logic r, input logic [19:0] a, input logic [15:0] d);
    logic [4:0] acks, busys;
    @(negedge clk);
    req = 1'b1; rw = r; adr = a; dtw = d;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req = 1'b0; rw = ~r; adr = a ^ 20'h00006; dtw = ~d;
      end
      acks[k]  = ack;
      busys[k] = busy;
    end
    chk({tag, " ack"},  {27'd0, acks},  32'b00100);
    chk({tag, " busy"}, {27'd0, busys}, 32'b01111);
  endtask

  initial begin
    logic [15:0] acks16;
    logic [4:0]  acks5;

    // Reset asserted between edges: outputs clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst ack",  {31'd0, ack},  32'd0);
    chk("rst err",  {31'd0, err},  32'd0);
    chk("rst dtr",  {16'd0, dtr},  32'h0000);
    chk("rst busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write then read.
    txn("wr4", 1'b0, 20'h00004, 16'h1234);
    chk("wr4 err", {31'd0, err}, 32'd0);
    txn("rd4", 1'b1, 20'h00004, 16'h0000);
    chk("rd4 dtr", {16'd0, dtr}, 32'h1234);
    chk("rd4 err", {31'd0, err}, 32'd0);

    // Back-to-back reads with req held: acks at t0+2, t0+7, t0+12.
    @(negedge clk);
    req = 1'b1; rw = 1'b1; adr = 20'h00004;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 13) req = 1'b0;
      acks16[k] = ack;
    end
    chk("b2b acks", {16'd0, acks16}, 32'h1084);
    chk("b2b dtr", {16'd0, dtr}, 32'h1234);

    // Out of window.
    txn("oow rd", 1'b1, 20'h80000, 16'h0000);
    chk("oow rd err", {31'd0, err}, 32'd1);
    chk("oow rd dtr", {16'd0, dtr}, 32'hFFFF);
    txn("oow wr", 1'b0, 20'h80004, 16'hBEEF);
    chk("oow wr err", {31'd0, err}, 32'd1);
    chk("oow wr dtr", {16'd0, dtr}, 32'hFFFF);
    txn("rd4b", 1'b1, 20'h00004, 16'h0000);
    chk("rd4b dtr", {16'd0, dtr}, 32'h1234);
    chk("rd4b err", {31'd0, err}, 32'd0);

    // Reset mid-BUSY abandons the write.
    txn("wr8", 1'b0, 20'h00008, 16'hAAAA);
    @(negedge clk);
    req = 1'b1; rw = 1'b0; adr = 20'h00008; dtw = 16'h5555;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acks5[k] = ack;
    end
    chk("midrst noack", {27'd0, acks5}, 32'd0);
    txn("rd8", 1'b1, 20'h00008, 16'h0000);
    chk("rd8 dtr", {16'd0, dtr}, 32'hAAAA);

    // adr[0] ignored.
    txn("wr5", 1'b0, 20'h00005, 16'h0F0F);
    txn("rd4c", 1'b1, 20'h00004, 16'h0000);
    chk("rd4c dtr", {16'd0, dtr}, 32'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
